// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - glyph constants and width helper for the seven-segment scanner
//
// Purpose: shared definitions for scan_n and seg_decoder.
//   SEG_0..SEG_F : segment patterns {a,b,c,d,e,f,g,dp}, 1 = lit, dp bit always 0
//   SEG_BLANK    : all segments off
//   clog2()      : ceiling log2 used to size counters (returns at least 1)
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hE6;
  localparam logic [7:0] SEG_A     = 8'hEE;
  localparam logic [7:0] SEG_B     = 8'h3E;
  localparam logic [7:0] SEG_C     = 8'h9C;
  localparam logic [7:0] SEG_D     = 8'h7A;
  localparam logic [7:0] SEG_E     = 8'h9E;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Width needed to count 0..n-1; never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// rtl/seg_decoder.sv - combinational hex nibble to seven-segment glyph lookup
//
// Purpose: maps one hex digit to its segment pattern.
// Ports:
//   i_nibble [3:0] : hex value to display
//   o_glyph  [7:0] : segments {a,b,c,d,e,f,g,dp}; dp (bit 0) is always 0
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_glyph
);

  always_comb begin
    o_glyph = SEG_BLANK;
    case (i_nibble)
      4'h0: o_glyph = SEG_0;
      4'h1: o_glyph = SEG_1;
      4'h2: o_glyph = SEG_2;
      4'h3: o_glyph = SEG_3;
      4'h4: o_glyph = SEG_4;
      4'h5: o_glyph = SEG_5;
      4'h6: o_glyph = SEG_6;
      4'h7: o_glyph = SEG_7;
      4'h8: o_glyph = SEG_8;
      4'h9: o_glyph = SEG_9;
      4'hA: o_glyph = SEG_A;
      4'hB: o_glyph = SEG_B;
      4'hC: o_glyph = SEG_C;
      4'hD: o_glyph = SEG_D;
      4'hE: o_glyph = SEG_E;
      4'hF: o_glyph = SEG_F;
      default: o_glyph = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/scan_n.sv
// rtl/scan_n.sv - parametrised multi-digit seven-segment scanner with PWM and frame latch
//
// Purpose: time-multiplexes DIGITS hex digits onto one segment bus, DIV clocks per
// digit slot, with per-digit decimal point, leading-zero blanking, PWM brightness
// and shadow registers that only change at frame boundaries.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   en               : scanner enable; low clears counters and blanks outputs
//   digits[4*DIGITS] : hex values, digit 0 in bits [3:0] (rightmost)
//   dp[DIGITS]       : decimal point per digit
//   blank_lz         : leading-zero blanking enable
//   brightness       : PWM duty, digit lit while pwm <= brightness
//   ena[DIGITS]      : one-hot registered digit enable, 1 = lit
//   light[8]         : registered segments {a,b,c,d,e,f,g,dp}, 1 = lit
//   frame_done       : one-cycle pulse when digit 0 of a new frame is first shown
module scan_n
  import seg_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int DIV      = 100000,
  parameter int PWM_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [DIGITS-1:0]     ena,
  output logic [7:0]            light,
  output logic                  frame_done
);

  localparam int CNT_W  = clog2(DIV);
  localparam int SLOT_W = clog2(DIGITS);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(DIGITS - 1);

  logic [CNT_W-1:0]    r_cnt;
  logic [SLOT_W-1:0]   r_slot;
  logic [PWM_BITS-1:0] r_pwm;
  logic                r_reload;
  logic                r_wrap;
  logic [4*DIGITS-1:0] r_sh_digits;
  logic [DIGITS-1:0]   r_sh_dp;
  logic                r_sh_blz;

  logic                w_tick;
  logic                w_last;
  logic                w_load;
  logic [4*DIGITS-1:0] w_view_digits;
  logic [DIGITS-1:0]   w_view_dp;
  logic                w_view_blz;
  logic [3:0]          w_nibble;
  logic                w_dp_bit;
  logic                w_higher_nz;
  logic                w_blank;
  logic                w_lit;
  logic [DIGITS-1:0]   w_onehot;
  logic [7:0]          w_glyph;
  logic [7:0]          w_seg;

  assign w_tick = (r_cnt == CNT_MAX);
  assign w_last = w_tick && (r_slot == SLOT_MAX);
  assign w_load = en && (r_reload || w_last);

  // On a pending reload (first enabled cycle after reset or en rising) the shadow
  // is being written on this very edge, so display straight from the inputs;
  // otherwise slot 0 would show stale content for one cycle. A wrap-time load is
  // for the next frame and must not leak into the last slot, hence r_reload only.
  assign w_view_digits = r_reload ? digits   : r_sh_digits;
  assign w_view_dp     = r_reload ? dp       : r_sh_dp;
  assign w_view_blz    = r_reload ? blank_lz : r_sh_blz;

  always_comb begin
    w_nibble    = 4'h0;
    w_dp_bit    = 1'b0;
    w_higher_nz = 1'b0;
    w_onehot    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_slot == SLOT_W'(i)) begin
        w_nibble    = w_view_digits[4*i +: 4];
        w_dp_bit    = w_view_dp[i];
        w_onehot[i] = 1'b1;
      end
      // Any nonzero digit at or above the current slot keeps it visible.
      if ((SLOT_W'(i) >= r_slot) && (w_view_digits[4*i +: 4] != 4'h0)) begin
        w_higher_nz = 1'b1;
      end
    end
  end

  assign w_blank = w_view_blz && (r_slot != '0) && !w_higher_nz;
  assign w_lit   = (r_pwm <= brightness);

  seg_decoder u_dec (
    .i_nibble (w_nibble),
    .o_glyph  (w_glyph)
  );

  // Decoder leaves bit 0 clear, so the dp bit can simply be ORed in.
  assign w_seg = (w_blank ? SEG_BLANK : w_glyph) | {7'b0, w_dp_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_slot      <= '0;
      r_pwm       <= '0;
      r_reload    <= 1'b1;
      r_wrap      <= 1'b0;
      r_sh_digits <= '0;
      r_sh_dp     <= '0;
      r_sh_blz    <= 1'b0;
      ena         <= '0;
      light       <= SEG_BLANK;
      frame_done  <= 1'b0;
    end else if (!en) begin
      r_cnt      <= '0;
      r_slot     <= '0;
      r_pwm      <= '0;
      r_reload   <= 1'b1;
      r_wrap     <= 1'b0;
      ena        <= '0;
      light      <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      r_cnt    <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        r_slot <= (r_slot == SLOT_MAX) ? '0 : r_slot + 1'b1;
      end
      r_pwm    <= r_pwm + 1'b1;
      r_reload <= 1'b0;
      if (w_load) begin
        r_sh_digits <= digits;
        r_sh_dp     <= dp;
        r_sh_blz    <= blank_lz;
      end
      // The wrap edge registers r_wrap; one edge later digit 0 of the new frame
      // reaches the outputs, and frame_done rises alongside it.
      r_wrap     <= w_last;
      frame_done <= r_wrap;
      if (w_lit) begin
        ena   <= w_onehot;
        light <= w_seg;
      end else begin
        ena   <= '0;
        light <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_scan_n.sv
// tb/tb_scan_n.sv - scoreboard testbench for scan_n
module tb_scan_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        en_a;
  logic [15:0] dig_a;
  logic [3:0]  dp_a;
  logic        blz_a;
  logic [1:0]  br_a;
  logic [3:0]  ena_a;
  logic [7:0]  light_a;
  logic        fd_a;

  logic        en_b;
  logic [31:0] dig_b;
  logic [7:0]  dp_b;
  logic        blz_b;
  logic [1:0]  br_b;
  logic [7:0]  ena_b;
  logic [7:0]  light_b;
  logic        fd_b;

  scan_n #(.DIGITS(4), .DIV(4), .PWM_BITS(2)) u_dut_a (
    .clk (clk), .rst (rst), .en (en_a), .digits (dig_a), .dp (dp_a),
    .blank_lz (blz_a), .brightness (br_a), .ena (ena_a), .light (light_a),
    .frame_done (fd_a)
  );

  scan_n #(.DIGITS(8), .DIV(3), .PWM_BITS(2)) u_dut_b (
    .clk (clk), .rst (rst), .en (en_b), .digits (dig_b), .dp (dp_b),
    .blank_lz (blz_b), .brightness (br_b), .ena (ena_b), .light (light_b),
    .frame_done (fd_b)
  );

  typedef struct packed {
    logic [7:0]  ena;
    logic [7:0]  light;
    logic        fd;
    logic [31:0] gap;   // cycles since previous output event, 0 = don't care
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int unsigned last_cyc [2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int w, input logic [7:0] e, input logic [7:0] l,
                      input logic f, input int unsigned g);
    exp_t x;
    x.ena = e; x.light = l; x.fd = f; x.gap = g;
    if (w == 0) q_a.push_back(x);
    else        q_b.push_back(x);
  endtask

  task automatic mon_sample(input int w, input logic [7:0] e, input logic [7:0] l, input logic f);
    exp_t x;
    int unsigned gap;
    int sz;
    gap = cyc - last_cyc[w];
    last_cyc[w] = cyc;
    checks++;
    sz = (w == 0) ? q_a.size() : q_b.size();
    if (sz == 0) begin
      errors++;
      $display("FAIL unexpected_out dut%0d: ena=%h light=%h fd=%b, required no output", w, e, l, f);
    end else begin
      if (w == 0) x = q_a.pop_front();
      else        x = q_b.pop_front();
      if (e !== x.ena || l !== x.light || f !== x.fd || (x.gap != 0 && gap != x.gap)) begin
        errors++;
        $display("FAIL scan dut%0d: ena=%h light=%h fd=%b gap=%0d, required ena=%h light=%h fd=%b gap=%0d",
                 w, e, l, f, gap, x.ena, x.light, x.fd, x.gap);
      end
    end
  endtask

  always @(negedge clk) if (!rst && (ena_a != 4'h0 || fd_a)) mon_sample(0, {4'h0, ena_a}, light_a, fd_a);
  always @(negedge clk) if (!rst && (ena_b != 8'h0 || fd_b)) mon_sample(1, ena_b, light_b, fd_b);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic chk_empty(input string name);
    chk({name, "_drained"}, q_a.size() + q_b.size(), 0);
    q_a.delete();
    q_b.delete();
  endtask

  // Hand-decoded glyphs, indexed by slot (digit 0 first).
  logic [7:0] l_1234 [4] = '{8'h66, 8'hF2, 8'hDA, 8'h60};
  logic [7:0] l_abcd [4] = '{8'h7A, 8'h9C, 8'h3E, 8'hEE};
  logic [7:0] l_blz  [4] = '{8'hFC, 8'hB6, 8'h00, 8'h01};
  logic [7:0] l_0050 [4] = '{8'hFC, 8'hB6, 8'hFC, 8'hFD};

  initial begin
    logic [7:0] oh;
    int s;
    rst = 1'b1;
    en_a = 1'b0; dig_a = '0; dp_a = '0; blz_a = 1'b0; br_a = 2'd3;
    en_b = 1'b0; dig_b = '0; dp_b = '0; blz_b = 1'b0; br_b = 2'd3;
    repeat (3) @(negedge clk);
    chk("reset_a", {19'h0, fd_a, ena_a, light_a}, 32'h0);
    chk("reset_b", {15'h0, fd_b, ena_b, light_b}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Scan sequence: three frames, frame_done at the start of frames 2 and 3.
    dig_a = 16'h1234;
    for (int i = 0; i < 48; i++) begin
      s = (i / 4) % 4; oh = 8'd1 << s;
      push(0, oh, l_1234[s], (i % 16 == 0) && (i > 0), (i == 0) ? 0 : 1);
    end
    en_a = 1'b1;
    repeat (48) @(negedge clk);
    en_a = 1'b0;
    repeat (3) @(negedge clk);
    chk_empty("scan");

    // Tearing: new digits mid-frame appear only from the next frame.
    for (int i = 0; i < 32; i++) begin
      s = (i / 4) % 4; oh = 8'd1 << s;
      push(0, oh, (i < 16) ? l_1234[s] : l_abcd[s], i == 16, (i == 0) ? 0 : 1);
    end
    en_a = 1'b1;
    repeat (6) @(negedge clk);
    dig_a = 16'hABCD;
    repeat (26) @(negedge clk);
    en_a = 1'b0;
    repeat (3) @(negedge clk);
    chk_empty("tearing");

    // Blanking, then blank_lz dropped mid-frame takes effect next frame.
    dig_a = 16'h0050; blz_a = 1'b1; dp_a = 4'b1000;
    for (int i = 0; i < 32; i++) begin
      s = (i / 4) % 4; oh = 8'd1 << s;
      push(0, oh, (i < 16) ? l_blz[s] : l_0050[s], i == 16, (i == 0) ? 0 : 1);
    end
    en_a = 1'b1;
    repeat (6) @(negedge clk);
    blz_a = 1'b0;
    repeat (26) @(negedge clk);
    en_a = 1'b0;
    repeat (3) @(negedge clk);
    chk_empty("blanking");

    // PWM brightness=1: 2 of 4 cycles lit per slot.
    dig_a = 16'h1234; dp_a = 4'b0000; br_a = 2'd1;
    for (int j = 0; j < 8; j++) begin
      s = j / 2; oh = 8'd1 << s;
      push(0, oh, l_1234[s], 1'b0, (j == 0) ? 0 : ((j % 2 == 1) ? 1 : 3));
    end
    en_a = 1'b1;
    repeat (16) @(negedge clk);
    en_a = 1'b0;
    repeat (3) @(negedge clk);
    chk_empty("pwm1");

    // PWM brightness=0: 1 of 4.
    br_a = 2'd0;
    for (int j = 0; j < 4; j++) begin
      oh = 8'd1 << j;
      push(0, oh, l_1234[j], 1'b0, (j == 0) ? 0 : 4);
    end
    en_a = 1'b1;
    repeat (16) @(negedge clk);
    en_a = 1'b0;
    repeat (3) @(negedge clk);
    chk_empty("pwm0");

    // Enable dropped mid-slot.
    br_a = 2'd3;
    for (int i = 0; i < 6; i++) push(0, (i < 4) ? 8'h01 : 8'h02, (i < 4) ? 8'h66 : 8'hF2, 1'b0, (i == 0) ? 0 : 1);
    en_a = 1'b1;
    repeat (6) @(negedge clk);
    en_a = 1'b0;
    @(negedge clk);
    chk("en_drop", {23'h0, fd_a, ena_a, light_a}, 32'h0);

    // Enable raised: restart at slot 0 with reloaded shadow (5678), then async reset.
    dig_a = 16'h5678;
    for (int i = 0; i < 8; i++) push(0, (i < 4) ? 8'h01 : 8'h02, (i < 4) ? 8'hFE : 8'hE0, 1'b0, (i == 0) ? 0 : 1);
    en_a = 1'b1;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst", {19'h0, fd_a, ena_a, light_a}, 32'h0);
    @(negedge clk);
    dig_a = 16'h9ABC;
    for (int i = 0; i < 4; i++) push(0, 8'h01, 8'h9C, 1'b0, (i == 0) ? 0 : 1);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    en_a = 1'b0;
    repeat (3) @(negedge clk);
    chk_empty("enable_reset");

    // Parameter sweep: 8 digits, 3 cycles per slot, only digit 0 shows a glyph.
    dig_b = 32'h0000_000F; blz_b = 1'b1;
    for (int i = 0; i < 48; i++) begin
      s = (i / 3) % 8; oh = 8'd1 << s;
      push(1, oh, (s == 0) ? 8'h8E : 8'h00, i == 24, (i == 0) ? 0 : 1);
    end
    en_b = 1'b1;
    repeat (48) @(negedge clk);
    en_b = 1'b0;
    repeat (3) @(negedge clk);
    chk_empty("sweep");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
